// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension stage: operand modes and
// the prefix FSM state type.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_PFX  = 2'b10,
    IMM_HIGH = 2'b11
  } imm_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    PFX_HELD = 1'b1
  } imm_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extend/place of an immediate operand. The operand is either
// the raw field alone or {pfx, imm} when a held prefix is being joined in;
// the sign bit for SEXT is the MSB of whichever operand is selected.
// Mode PFX never reaches here as a result-producing mode in the prefix build,
// so it shares the SEXT path (which is also its meaning without prefixes).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int PFX_W = 12,
  parameter int OUT_W = 18
) (
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  imm,
  input  logic [PFX_W-1:0] pfx,
  input  logic             use_pfx,
  output logic [OUT_W-1:0] ext
);

  localparam int V_W = PFX_W + IN_W;

  logic [V_W-1:0]   v_long;
  logic [OUT_W-1:0] sext_long, sext_short, zext_long, zext_short, high_val;

  assign v_long     = {pfx, imm};
  assign sext_long  = OUT_W'($signed(v_long));
  assign sext_short = OUT_W'($signed(imm));
  assign zext_long  = OUT_W'(v_long);
  assign zext_short = OUT_W'(imm);
  assign high_val   = zext_short << (OUT_W - IN_W);

  // Select the extended value for the requested mode
  always_comb begin
    ext = '0;
    case (mode)
      IMM_ZEXT: ext = use_pfx ? zext_long : zext_short;
      IMM_HIGH: ext = high_val;
      default:  ext = use_pfx ? sext_long : sext_short;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage between decode and the ALU operand mux.
// Handshake: a side transfers when valid & ready are both high on a rising
// edge; in_ready = !out_valid | out_ready, so the 1-deep output register can
// be refilled in the same cycle it is drained. valid never depends on ready.
// Optional feature macro: IMM_EXT_PFX_EN enables the prefix register, the
// PFX_HELD state and out_pfx_used. Without it mode 10 behaves as SEXT.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int PFX_W = 12,
  parameter int OUT_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_pfx_used,
  output imm_state_e       dbg_state
);

  logic             in_fire;
  logic             take_result;
  logic             use_pfx;
  logic [PFX_W-1:0] pfx_q;
  logic [OUT_W-1:0] ext;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

`ifdef IMM_EXT_PFX_EN
  imm_state_e       state_q, state_n;
  logic [PFX_W-1:0] pfx_n;
  logic             is_pfx;

  assign is_pfx    = (in_mode == IMM_PFX);
  // A held prefix joins SEXT/ZEXT operands; HIGH discards it.
  assign use_pfx   = (state_q == PFX_HELD) && !is_pfx && (in_mode != IMM_HIGH);
  assign dbg_state = state_q;

  // Next-state: collect prefixes, release to IDLE on any non-prefix fire
  always_comb begin
    state_n     = state_q;
    pfx_n       = pfx_q;
    take_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_fire) begin
          if (is_pfx) begin
            pfx_n   = PFX_W'(in_imm);
            state_n = PFX_HELD;
          end else begin
            take_result = 1'b1;
          end
        end
      end
      PFX_HELD: begin
        if (in_fire) begin
          if (is_pfx) begin
            pfx_n = PFX_W'({pfx_q, in_imm});
          end else begin
            take_result = 1'b1;
            state_n     = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and prefix register; flush drops any held prefix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pfx_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      pfx_q   <= '0;
    end else begin
      state_q <= state_n;
      pfx_q   <= pfx_n;
    end
  end
`else
  assign pfx_q       = '0;
  assign use_pfx     = 1'b0;
  assign take_result = in_fire;
  assign dbg_state   = IDLE;
`endif

  imm_ext_core #(
    .IN_W  (IN_W),
    .PFX_W (PFX_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode    (in_mode),
    .imm     (in_imm),
    .pfx     (pfx_q),
    .use_pfx (use_pfx),
    .ext     (ext)
  );

  // Output register: load on a result-producing fire, drop on drain, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_pfx_used <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_pfx_used <= 1'b0;
    end else if (take_result) begin
      out_valid    <= 1'b1;
      out_imm      <= ext;
      out_pfx_used <= use_pfx;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule
